// File: rtl/tlul_sram_bist_host.sv
// tlul_sram_bist_host: TL-UL host that writes seed^address over a word range,
// reads it back and counts data mismatches and d_error responses.
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    parameter logic [3:0] MuBi4False = 4'h9;

    typedef struct packed {
        logic [4:0] rsvd;
        logic [3:0] instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic       rsp_intg_unused_hi;
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        tl_d_user_t  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    // Hamming check bits plus overall parity over a 57-bit payload.
    function automatic logic [6:0] secd(input logic [56:0] d);
        logic [6:0] p;
        p = '0;
        for (int j = 0; j < 57; j++) begin
            for (int i = 0; i < 6; i++) begin
                if ((((j + 1) >> i) & 1) != 0) p[i] = p[i] ^ d[j];
            end
            p[6] = p[6] ^ d[j];
        end
        return p;
    endfunction

endpackage

module tlul_cmd_intg_gen (
    input  tlul_pkg::tl_h2d_t tl_i,
    output tlul_pkg::tl_h2d_t tl_o
);
    always_comb begin
        tl_o = tl_i;
        tl_o.a_user.cmd_intg  = tlul_pkg::secd(57'({tl_i.a_user.instr_type, tl_i.a_address,
                                                     tl_i.a_opcode, tl_i.a_mask}));
        tl_o.a_user.data_intg = tlul_pkg::secd(57'(tl_i.a_data));
    end
endmodule

module tlul_sram_bist_host #(
    parameter int Outstanding = 2,
    parameter int CntW        = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [31:0]       base_addr_i,
    input  logic [CntW-1:0]   num_words_i,
    input  logic [31:0]       seed_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [CntW-1:0]   err_count_o,
    output logic [31:0]       first_err_addr_o,
    output tlul_pkg::tl_h2d_t tl_o,
    input  tlul_pkg::tl_d2h_t tl_i
);
    import tlul_pkg::*;

    localparam int IfW = $clog2(Outstanding + 1);

    typedef enum logic [2:0] {Idle, Write, WDrain, Read, RDrain, Done} state_e;

    state_e          state, state_d;
    logic [31:0]     base, seed, first_err, a_addr, rsp_addr;
    logic [CntW-1:0] num, issue_idx, rsp_idx, err_cnt;
    logic [IfW-1:0]  inflight;
    logic            busy, done, active, reading, issuing, a_acc, d_acc, rsp_bad, start;
    tl_h2d_t         tl_pre;
    logic            unused_tl;

    assign start    = state == Idle && start_i;
    assign active   = state inside {Write, WDrain, Read, RDrain};
    assign reading  = state inside {Read, RDrain};
    assign issuing  = (state == Write || state == Read) && issue_idx < num
                      && inflight < IfW'(Outstanding);
    assign a_acc    = issuing && tl_i.a_ready;
    // A zero in-flight count guards against stray responses from an abandoned run.
    assign d_acc    = active && tl_i.d_valid && inflight != '0;
    assign a_addr   = base + 32'({issue_idx, 2'b00});
    assign rsp_addr = base + 32'({rsp_idx, 2'b00});
    assign rsp_bad  = d_acc && (tl_i.d_error || (reading && tl_i.d_data != (seed ^ rsp_addr)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= Idle;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            Idle:    if (start_i) state_d = num_words_i == '0 ? Done : Write;
            Write:   if (issue_idx == num) state_d = WDrain;
            WDrain:  if (inflight == '0) state_d = Read;
            Read:    if (issue_idx == num) state_d = RDrain;
            RDrain:  if (inflight == '0) state_d = Done;
            Done:    state_d = Idle;
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            base      <= '0;
            seed      <= '0;
            num       <= '0;
            issue_idx <= '0;
            rsp_idx   <= '0;
            inflight  <= '0;
            err_cnt   <= '0;
            first_err <= '0;
        end else begin
            busy <= state_d != Idle;
            done <= state == Done;
            if (start) begin
                base      <= {base_addr_i[31:2], 2'b00};
                seed      <= seed_i;
                num       <= num_words_i;
                issue_idx <= '0;
                rsp_idx   <= '0;
                inflight  <= '0;
                err_cnt   <= '0;
                first_err <= '0;
            end else begin
                if (state == WDrain && inflight == '0) begin
                    issue_idx <= '0;
                    rsp_idx   <= '0;
                end else begin
                    if (a_acc) issue_idx <= issue_idx + CntW'(1);
                    if (d_acc) rsp_idx <= rsp_idx + CntW'(1);
                end
                if (a_acc != d_acc) inflight <= a_acc ? inflight + IfW'(1) : inflight - IfW'(1);
                if (rsp_bad) begin
                    if (err_cnt != '1) err_cnt <= err_cnt + CntW'(1);
                    if (err_cnt == '0) first_err <= rsp_addr;
                end
            end
        end
    end

    always_comb begin
        tl_pre                   = '0;
        tl_pre.a_valid           = issuing;
        tl_pre.a_opcode          = state == Read ? Get : PutFullData;
        tl_pre.a_size            = 2'd2;
        tl_pre.a_source          = 8'(issue_idx % CntW'(Outstanding));
        tl_pre.a_address         = a_addr;
        tl_pre.a_mask            = 4'hF;
        tl_pre.a_data            = state == Read ? 32'd0 : seed ^ a_addr;
        tl_pre.a_user.instr_type = MuBi4False;
        tl_pre.d_ready           = 1'b1;
    end

    tlul_cmd_intg_gen u_intg (
        .tl_i(tl_pre),
        .tl_o(tl_o)
    );

    assign unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                         tl_i.d_sink, tl_i.d_user};

    assign busy_o           = busy;
    assign done_o           = done;
    assign error_o          = err_cnt != '0;
    assign err_count_o      = err_cnt;
    assign first_err_addr_o = first_err;
endmodule

// File: tb/tb_tlul_sram_bist_host.sv
// tb_tlul_sram_bist_host: directed checks of the SRAM BIST host against a
// small TL-UL SRAM model with stall, hold, corruption and d_error knobs.
module tb_tlul_sram_bist_host;
    import tlul_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [31:0] base_addr = '0, seed = '0;
    logic [15:0] num_words = '0;
    logic        busy, done, error;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;
    tl_h2d_t     tl_h;
    tl_d2h_t     tl_d;

    logic        stall = 1'b0, d_hold = 1'b0;
    logic [31:0] corrupt_addr = 32'hFFFF_FFFF;
    int          derr_get = 0;
    int          passed = 0, total = 0;

    logic [31:0] mem [256];
    logic [31:0] f_data [8];
    logic        f_err [8];
    logic        f_put [8];
    logic [7:0]  f_src [8];
    logic [3:0]  wp = '0, rp = '0;
    logic        a_acc;

    int n_put = 0, n_get = 0, n_done = 0, av_cnt = 0, seq_bad = 0, infl = 0, max_infl = 0;

    always #5 clk = ~clk;

    tlul_sram_bist_host #(.Outstanding(2), .CntW(16)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .base_addr_i     (base_addr),
        .num_words_i     (num_words),
        .seed_i          (seed),
        .busy_o          (busy),
        .done_o          (done),
        .error_o         (error),
        .err_count_o     (err_count),
        .first_err_addr_o(first_err_addr),
        .tl_o            (tl_h),
        .tl_i            (tl_d)
    );

    assign a_acc = tl_h.a_valid && tl_d.a_ready;

    always_comb begin
        tl_d          = '0;
        tl_d.a_ready  = !stall;
        tl_d.d_valid  = wp != rp && !d_hold;
        tl_d.d_opcode = f_put[rp[2:0]] ? AccessAck : AccessAckData;
        tl_d.d_size   = 2'd2;
        tl_d.d_source = f_src[rp[2:0]];
        tl_d.d_data   = f_data[rp[2:0]];
        tl_d.d_error  = f_err[rp[2:0]];
    end

    // SRAM model: one-cycle response latency, responses queued in order.
    always @(posedge clk) begin
        if (tl_d.d_valid) rp <= rp + 4'd1;
        if (a_acc) begin
            if (tl_h.a_opcode == PutFullData) mem[tl_h.a_address[9:2]] <= tl_h.a_data;
            f_put[wp[2:0]]  <= tl_h.a_opcode == PutFullData;
            f_src[wp[2:0]]  <= tl_h.a_source;
            f_data[wp[2:0]] <= tl_h.a_opcode == Get
                ? mem[tl_h.a_address[9:2]] ^ {31'd0, tl_h.a_address == corrupt_addr} : 32'd0;
            f_err[wp[2:0]]  <= tl_h.a_opcode == Get && n_get + 1 == derr_get;
            wp <= wp + 4'd1;
        end
    end

    always @(posedge clk) begin
        infl <= infl + (a_acc ? 1 : 0) - (tl_d.d_valid ? 1 : 0);
        if (start && !busy) begin
            n_put <= 0; n_get <= 0; n_done <= 0; av_cnt <= 0; seq_bad <= 0; max_infl <= 0;
        end else begin
            if (tl_h.a_valid) av_cnt <= av_cnt + 1;
            if (done) n_done <= n_done + 1;
            if (infl + (a_acc ? 1 : 0) - (tl_d.d_valid ? 1 : 0) > max_infl)
                max_infl <= infl + (a_acc ? 1 : 0) - (tl_d.d_valid ? 1 : 0);
            if (a_acc && tl_h.a_opcode == PutFullData) begin
                n_put <= n_put + 1;
                if (tl_h.a_address != base_addr + 32'(n_put * 4) || tl_h.a_data != (seed ^ tl_h.a_address)
                    || tl_h.a_source != 8'(n_put % 2) || n_get != 0 || tl_h.a_mask != 4'hF)
                    seq_bad <= seq_bad + 1;
            end
            if (a_acc && tl_h.a_opcode == Get) begin
                n_get <= n_get + 1;
                if (tl_h.a_address != base_addr + 32'(n_get * 4) || tl_h.a_data != 32'd0
                    || tl_h.a_source != 8'(n_get % 2) || n_put != int'(num_words))
                    seq_bad <= seq_bad + 1;
            end
        end
    end

    task automatic kick(input logic [31:0] b, input logic [15:0] n, input logic [31:0] s);
        @(negedge clk);
        base_addr = b; num_words = n; seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        for (int i = 0; i < 2000 && !done; i++) @(negedge clk);
        ok = done;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
        total++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else passed++;
        total++; if (err_count !== 16'd0) $display("FAIL reset_errcnt: got %0d want 0", err_count); else passed++;
        total++; if (first_err_addr !== 32'd0) $display("FAIL reset_first: got %h want 0", first_err_addr); else passed++;
        total++; if (tl_h.a_valid !== 1'b0) $display("FAIL reset_avalid: got %b want 0", tl_h.a_valid); else passed++;
        total++; if (tl_h.d_ready !== 1'b1) $display("FAIL reset_dready: got %b want 1", tl_h.d_ready); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit ok;
        kick(32'h0, 16'd8, 32'hA5A5_A5A5);
        total++; if (busy !== 1'b1) $display("FAIL basic_busy_rise: got %b want 1", busy); else passed++;
        wait_done(ok);
        total++; if (!ok) $display("FAIL basic_timeout: done_o got 0 want 1"); else passed++;
        total++; if (n_put !== 8) $display("FAIL basic_puts: got %0d want 8", n_put); else passed++;
        total++; if (n_get !== 8) $display("FAIL basic_gets: got %0d want 8", n_get); else passed++;
        total++; if (seq_bad !== 0) $display("FAIL basic_seq: got %0d bad beats want 0", seq_bad); else passed++;
        total++; if (n_done !== 1) $display("FAIL basic_done_pulses: got %0d want 1", n_done); else passed++;
        total++; if (error !== 1'b0) $display("FAIL basic_error: got %b want 0", error); else passed++;
        total++; if (err_count !== 16'd0) $display("FAIL basic_errcnt: got %0d want 0", err_count); else passed++;
        total++; if (first_err_addr !== 32'd0) $display("FAIL basic_first: got %h want 0", first_err_addr); else passed++;
        total++; if (mem[3] !== 32'hA5A5_A5A9) $display("FAIL basic_mem3: got %h want a5a5a5a9", mem[3]); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL basic_busy_fall: got %b want 0", busy); else passed++;
    endtask

    task automatic test_zero_words;
        kick(32'h80, 16'd0, 32'h1);
        total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL zero_c1: got busy=%b done=%b want 1/0", busy, done); else passed++;
        @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b1) $display("FAIL zero_c2: got busy=%b done=%b want 0/1", busy, done); else passed++;
        @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL zero_c3: got busy=%b done=%b want 0/0", busy, done); else passed++;
        total++; if (av_cnt !== 0) $display("FAIL zero_avalid: got %0d valid cycles want 0", av_cnt); else passed++;
        total++; if (n_done !== 1) $display("FAIL zero_done_pulses: got %0d want 1", n_done); else passed++;
    endtask

    task automatic test_stall;
        bit ok;
        kick(32'h40, 16'd8, 32'h1234_5678);
        for (int i = 0; i < 100 && n_put < 3; i++) @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (tl_h.a_valid !== 1'b1 || tl_h.a_address !== 32'h4C || tl_h.a_data !== 32'h1234_5634)
                $display("FAIL stall_hold%0d: got v=%b a=%h d=%h want 1/4c/12345634", i, tl_h.a_valid, tl_h.a_address, tl_h.a_data);
            else passed++;
            @(negedge clk);
        end
        total++; if (n_put !== 3) $display("FAIL stall_no_accept: got %0d puts want 3", n_put); else passed++;
        stall = 1'b0;
        wait_done(ok);
        total++; if (!ok) $display("FAIL stall_timeout: done_o got 0 want 1"); else passed++;
        total++; if (n_put !== 8 || n_get !== 8) $display("FAIL stall_beats: got %0d/%0d want 8/8", n_put, n_get); else passed++;
        total++; if (seq_bad !== 0) $display("FAIL stall_seq: got %0d bad beats want 0", seq_bad); else passed++;
        total++; if (max_infl > 2) $display("FAIL stall_inflight: got max %0d want <=2", max_infl); else passed++;
        total++; if (err_count !== 16'd0) $display("FAIL stall_errcnt: got %0d want 0", err_count); else passed++;
    endtask

    task automatic test_fault;
        bit ok;
        corrupt_addr = 32'h10C;
        kick(32'h100, 16'd8, 32'hDEAD_BEEF);
        wait_done(ok);
        corrupt_addr = 32'hFFFF_FFFF;
        total++; if (!ok) $display("FAIL fault_timeout: done_o got 0 want 1"); else passed++;
        total++; if (err_count !== 16'd1) $display("FAIL fault_errcnt: got %0d want 1", err_count); else passed++;
        total++; if (first_err_addr !== 32'h10C) $display("FAIL fault_first: got %h want 10c", first_err_addr); else passed++;
        total++; if (error !== 1'b1) $display("FAIL fault_error: got %b want 1", error); else passed++;
    endtask

    task automatic test_d_error;
        bit ok;
        derr_get = 2;
        kick(32'h200, 16'd4, 32'h0);
        total++; if (error !== 1'b0) $display("FAIL derr_clear_on_start: got %b want 0", error); else passed++;
        wait_done(ok);
        derr_get = 0;
        total++; if (!ok) $display("FAIL derr_timeout: done_o got 0 want 1"); else passed++;
        total++; if (err_count !== 16'd1) $display("FAIL derr_errcnt: got %0d want 1", err_count); else passed++;
        total++; if (first_err_addr !== 32'h204) $display("FAIL derr_first: got %h want 204", first_err_addr); else passed++;
        total++; if (error !== 1'b1) $display("FAIL derr_error: got %b want 1", error); else passed++;
    endtask

    task automatic test_reset_mid_read;
        bit ok;
        kick(32'h0, 16'd8, 32'h1111_0000);
        total++; if (error !== 1'b0) $display("FAIL mid_clear_on_start: got %b want 0", error); else passed++;
        for (int i = 0; i < 200 && !(tl_h.a_valid && tl_h.a_opcode == Get); i++) @(negedge clk);
        d_hold = 1'b1;
        for (int i = 0; i < 50 && infl < 2; i++) @(negedge clk);
        total++; if (infl !== 2 || busy !== 1'b1) $display("FAIL mid_two_inflight: got infl=%0d busy=%b want 2/1", infl, busy); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mid_rst_busy: got busy=%b done=%b want 0/0", busy, done); else passed++;
        total++; if (tl_h.a_valid !== 1'b0) $display("FAIL mid_rst_avalid: got %b want 0", tl_h.a_valid); else passed++;
        total++; if (err_count !== 16'd0 || first_err_addr !== 32'd0) $display("FAIL mid_rst_err: got %0d/%h want 0/0", err_count, first_err_addr); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        d_hold = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (infl !== 0 || busy !== 1'b0) $display("FAIL mid_late_rsp: got infl=%0d busy=%b want 0/0", infl, busy); else passed++;
        kick(32'h300, 16'd4, 32'h0F0F_0F0F);
        wait_done(ok);
        total++; if (!ok) $display("FAIL mid_rerun_timeout: done_o got 0 want 1"); else passed++;
        total++; if (n_put !== 4 || n_get !== 4) $display("FAIL mid_rerun_beats: got %0d/%0d want 4/4", n_put, n_get); else passed++;
        total++; if (err_count !== 16'd0 || error !== 1'b0) $display("FAIL mid_rerun_err: got %0d/%b want 0/0", err_count, error); else passed++;
        total++; if (seq_bad !== 0) $display("FAIL mid_rerun_seq: got %0d bad beats want 0", seq_bad); else passed++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero_words;
        test_fault;
        test_d_error;
        test_reset_mid_read;
        test_stall;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
